ibex_div_seq: RTL and testbench



---
 rtl/ibex_div_seq_if.sv | 32 +++
 rtl/ibex_div_seq.sv | 135 +++++++++++++
 tb/tb_ibex_div_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ibex_div_seq_if.sv
// Request/response and shared-adder signals of the iterative divider.
// master = requester plus ALU adder side, slave = ibex_div_seq.
interface ibex_div_seq_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  operator_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        abort_i;
    logic        multdiv_sel_o;
    logic [32:0] alu_operand_a_o;
    logic [32:0] alu_operand_b_o;
    logic [33:0] alu_adder_result_ext_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;

    modport master (
        output in_valid_i, operator_i, signed_i, dividend_i, divisor_i, abort_i,
               out_ready_i, alu_adder_result_ext_i,
        input  in_ready_o, multdiv_sel_o, alu_operand_a_o, alu_operand_b_o,
               out_valid_o, result_o
    );

    modport slave (
        input  in_valid_i, operator_i, signed_i, dividend_i, divisor_i, abort_i,
               out_ready_i, alu_adder_result_ext_i,
        output in_ready_o, multdiv_sel_o, alu_operand_a_o, alu_operand_b_o,
               out_valid_o, result_o
    );
endinterface

// File: rtl/ibex_div_seq.sv
// Radix-2 restoring DIV/DIVU/REM/REMU sequencer that borrows the ALU adder.
// Optional macro IBEX_DIV_EARLY_EXIT_EN skips the iterations when |a| < |b|.
module ibex_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk_i,
    input logic            rst_i,
    ibex_div_seq_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StPrep, StDiv, StFix, StDone} state_e;

    state_e           r_state, w_state_next;
    logic             r_op_rem, r_signed, r_q_neg, r_r_neg;
    logic [WIDTH-1:0] r_dividend, r_divisor, r_dvd, r_result;
    logic [WIDTH:0]   r_rem, r_neg_b;
    logic [4:0]       r_cnt;

    logic             w_a_neg, w_b_neg, w_div_zero, w_early, w_carry;
    logic             w_unused_rem_msb;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_quot, w_remd;
    logic [WIDTH:0]   w_shifted;

    // 32-bit negation then zero-extend, so -2^31 yields magnitude 2^31
    assign w_a_neg    = r_signed & r_dividend[WIDTH-1];
    assign w_b_neg    = r_signed & r_divisor[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -r_dividend : r_dividend;
    assign w_b_abs    = w_b_neg ? -r_divisor : r_divisor;
    assign w_div_zero = (r_divisor == '0);
    assign w_shifted  = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_carry    = bus.alu_adder_result_ext_i[WIDTH+1];
    assign w_quot     = r_q_neg ? -r_dvd : r_dvd;
    assign w_remd     = r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    assign w_unused_rem_msb = r_rem[WIDTH];

`ifdef IBEX_DIV_EARLY_EXIT_EN
    assign w_early = ({1'b0, w_a_abs} < {1'b0, w_b_abs});
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        bus.in_ready_o      = 1'b0;
        bus.multdiv_sel_o   = 1'b0;
        bus.out_valid_o     = 1'b0;
        bus.alu_operand_a_o = '0;
        bus.alu_operand_b_o = '0;
        bus.result_o        = r_result;
        unique case (r_state)
            StIdle: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) w_state_next = StPrep;
            end
            StPrep: begin
                if (w_div_zero)   w_state_next = StDone;
                else if (w_early) w_state_next = StFix;
                else              w_state_next = StDiv;
            end
            StDiv: begin
                bus.multdiv_sel_o   = 1'b1;
                bus.alu_operand_a_o = w_shifted;
                bus.alu_operand_b_o = r_neg_b;
                if (r_cnt == 5'd31) w_state_next = StFix;
            end
            StFix: w_state_next = StDone;
            StDone: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (bus.abort_i && (r_state != StIdle)) w_state_next = StIdle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op_rem   <= 1'b0;
            r_signed   <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_dvd      <= '0;
            r_result   <= '0;
            r_rem      <= '0;
            r_neg_b    <= '0;
            r_cnt      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid_i) begin
                        r_op_rem   <= (bus.operator_i == 2'd3);
                        r_signed   <= bus.signed_i;
                        r_dividend <= bus.dividend_i;
                        r_divisor  <= bus.divisor_i;
                    end
                end
                StPrep: begin
                    r_neg_b <= '0 - {1'b0, w_b_abs};
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_cnt   <= '0;
                    if (w_div_zero) begin
                        r_result <= r_op_rem ? r_dividend : '1;
                    end
                    // Early exit: quotient is zero and the dividend is the remainder
                    if (w_early) begin
                        r_dvd <= '0;
                        r_rem <= {1'b0, w_a_abs};
                    end else begin
                        r_dvd <= w_a_abs;
                        r_rem <= '0;
                    end
                end
                StDiv: begin
                    r_rem <= w_carry ? bus.alu_adder_result_ext_i[WIDTH:0] : w_shifted;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_carry};
                    r_cnt <= r_cnt + 5'd1;
                end
                StFix: r_result <= r_op_rem ? w_remd : w_quot;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_div_seq.sv
// Directed bench for ibex_div_seq; models the ALU adder as a plain 34-bit sum.
module tb_ibex_div_seq;

    logic clk = 1'b0;
    logic rst;

    ibex_div_seq_if bus ();

    ibex_div_seq #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.alu_adder_result_ext_i = {1'b0, bus.alu_operand_a_o} + {1'b0, bus.alu_operand_b_o};

`ifdef IBEX_DIV_EARLY_EXIT_EN
    localparam int LatEarly = 2;
    localparam int SelEarly = 0;
`else
    localparam int LatEarly = 34;
    localparam int SelEarly = 32;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] res;
    int          lat, sel_cnt, sel_runs, seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic start(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
        bus.operator_i = op;
        bus.signed_i   = sgn;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        logic prev;
        prev     = 1'b0;
        lat      = 0;
        sel_cnt  = 0;
        sel_runs = 0;
        while (!bus.out_valid_o && lat < 100) begin
            if (bus.multdiv_sel_o) begin
                sel_cnt++;
                if (!prev) sel_runs++;
            end
            prev = bus.multdiv_sel_o;
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
        res = bus.result_o;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        start(op, sgn, a, b);
        wait_result(tag);
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
    endtask

    task automatic watch_no_valid(input string tag);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid_o) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.operator_i  = 2'd0;
        bus.signed_i    = 1'b0;
        bus.dividend_i  = '0;
        bus.divisor_i   = '0;
        bus.abort_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst_sel", 64'(bus.multdiv_sel_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_result", 64'(bus.result_o), 64'd0);
        check("rst_opa", 64'(bus.alu_operand_a_o), 64'd0);
        check("rst_opb", 64'(bus.alu_operand_b_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned basics and iteration window
        run_op("divu_100_7", 2'd2, 1'b0, 32'd100, 32'd7, 32'd14, 34);
        check("divu_sel_cnt", 64'(sel_cnt), 64'd32);
        check("divu_sel_runs", 64'(sel_runs), 64'd1);
        run_op("remu_100_7", 2'd3, 1'b0, 32'd100, 32'd7, 32'd2, 34);
        run_op("op0_is_div", 2'd0, 1'b0, 32'd100, 32'd7, 32'd14, 34);
        run_op("divu_max_1", 2'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

        // Signed
        run_op("div_m7_2", 2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", 2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("div_7_m2", 2'd2, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem_7_m2", 2'd3, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("div_ovf", 2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("rem_ovf", 2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // Divide by zero
        run_op("div_by0", 2'd2, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        check("div_by0_sel", 64'(sel_cnt), 64'd0);
        run_op("rem_by0", 2'd3, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_op("rem_by0_neg", 2'd3, 1'b1, 32'h8000_0001, 32'd0, 32'h8000_0001, 1);

        // Backpressure, then a request presented while DONE is released
        bus.out_ready_i = 1'b0;
        start(2'd2, 1'b0, 32'd1000, 32'd10);
        wait_result("bp");
        check("bp_res", 64'(res), 64'd100);
        check("bp_lat", 64'(lat), 64'd34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("bp_hold_result", 64'(bus.result_o), 64'd100);
            check("bp_hold_in_ready", 64'(bus.in_ready_o), 64'd0);
        end
        bus.out_ready_i = 1'b1;
        bus.operator_i  = 2'd2;
        bus.signed_i    = 1'b0;
        bus.dividend_i  = 32'd81;
        bus.divisor_i   = 32'd9;
        bus.in_valid_i  = 1'b1;
        @(negedge clk);
        check("bp_idle_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("bp_idle_out_valid", 64'(bus.out_valid_o), 64'd0);
        run_op("b2b_81_9", 2'd2, 1'b0, 32'd81, 32'd9, 32'd9, 34);

        // Abort at iteration 10
        start(2'd2, 1'b0, 32'hFFFF_FFFF, 32'd3);
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("abort_sel_before", 64'(bus.multdiv_sel_o), 64'd1);
        check("abort_opa_it10", 64'(bus.alu_operand_a_o), 64'd1);
        check("abort_opb_it10", 64'(bus.alu_operand_b_o), 64'h1_FFFF_FFFD);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("abort_sel", 64'(bus.multdiv_sel_o), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid_o), 64'd0);
        watch_no_valid("abort_no_result");
        run_op("post_abort_9_3", 2'd2, 1'b0, 32'd9, 32'd3, 32'd3, 34);

        // Reset at iteration 20
        start(2'd2, 1'b0, 32'hFFFF_FFFF, 32'd3);
        @(negedge clk);
        repeat (20) @(negedge clk);
        check("rst20_sel_before", 64'(bus.multdiv_sel_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst20_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst20_sel", 64'(bus.multdiv_sel_o), 64'd0);
        check("rst20_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst20_result", 64'(bus.result_o), 64'd0);
        check("rst20_opa", 64'(bus.alu_operand_a_o), 64'd0);
        watch_no_valid("rst20_no_result");
        run_op("post_rst_9_3", 2'd2, 1'b0, 32'd9, 32'd3, 32'd3, 34);

        // Small dividend: early exit when the feature is built in
        run_op("divu_5_9", 2'd2, 1'b0, 32'd5, 32'd9, 32'd0, LatEarly);
        check("divu_5_9_sel", 64'(sel_cnt), 64'(SelEarly));
        run_op("remu_5_9", 2'd3, 1'b0, 32'd5, 32'd9, 32'd5, LatEarly);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
